// File: rtl/mfp_uart_receiver_cfg.sv
// mfp_uart_receiver_cfg
//   16x-oversampling UART receiver with configurable data width, parity and
//   stop-bit count. Each bit is decided by a 3-sample majority vote
//   (samples 7, 8, 9). The receiver rejects false starts, and flags parity,
//   framing, break and overrun conditions. A received byte is held with
//   byte_valid until the consumer acknowledges it.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   rx             asynchronous serial input, idles high
//   byte_data      received data word, first line bit in bit 0
//   byte_valid     byte_data and the error flags are valid; held until ack
//   byte_ack       consumer acknowledge, ignored while byte_valid = 0
//   parity_error   parity mismatch for the held byte (0 when PARITY = 0)
//   framing_error  some stop bit of the held byte was sampled 0
//   break_detect   one-cycle pulse when a break frame completes
//   overrun_error  one-cycle pulse when a completed frame is dropped
module mfp_uart_receiver_cfg #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int TICK_DIV        = CLOCK_FREQUENCY / (BAUD_RATE * 16)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_valid,
  input  logic                 byte_ack,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 break_detect,
  output logic                 overrun_error
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_t;

  state_t               state_q;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [3:0]           sample_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic                 s7_q, s8_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_bit_q, par_err_q, first_stop_q, fe_q;
  logic [DATA_BITS-1:0] byte_q;
  logic                 vld_q, pe_q, fe_out_q, brk_q, ovr_q;

  logic start_edge, tick, maj, smp9, smp15;
  logic par_exp, fe_now, brk_now;

  // Two-flop synchroniser plus a previous-value flop for edge detection.
  // All three reset to the idle (high) line level so that reset release
  // cannot look like a start edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;
  assign tick       = (tick_cnt_q == TICK_LAST);

  // The oversample tick free-runs. It is re-phased on the start edge so that
  // sample 8 lands near the middle of each bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           tick_cnt_q <= '0;
    else if (state_q == S_IDLE && start_edge) tick_cnt_q <= '0;
    else if (tick)                          tick_cnt_q <= '0;
    else                                    tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  assign maj     = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);
  assign smp9    = tick && (sample_cnt_q == 4'd9);
  assign smp15   = tick && (sample_cnt_q == 4'd15);
  assign par_exp = (PARITY == 1) ? ~^data_q : ^data_q;
  // Values for the cycle in which the last stop bit is decided.
  assign fe_now  = fe_q | ~maj;
  assign brk_now = (data_q == '0) && ((PARITY == 0) || !par_bit_q) &&
                   !((STOP_BITS == 1) ? maj : first_stop_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      s7_q         <= 1'b0;
      s8_q         <= 1'b0;
      data_q       <= '0;
      par_bit_q    <= 1'b0;
      par_err_q    <= 1'b0;
      first_stop_q <= 1'b0;
      fe_q         <= 1'b0;
      byte_q       <= '0;
      vld_q        <= 1'b0;
      pe_q         <= 1'b0;
      fe_out_q     <= 1'b0;
      brk_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
      // An ack clears valid. A load later in this block overrides the clear,
      // so a simultaneous ack and load keeps byte_valid high.
      if (vld_q && byte_ack) vld_q <= 1'b0;

      if (state_q != S_IDLE && state_q != S_BRK && tick) begin
        sample_cnt_q <= sample_cnt_q + 4'd1;
        if (sample_cnt_q == 4'd7) s7_q <= rx_sync_q;
        if (sample_cnt_q == 4'd8) s8_q <= rx_sync_q;
      end

      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q      <= S_START;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            fe_q         <= 1'b0;
          end
        end
        S_START: begin
          if (smp9 && maj)  state_q <= S_IDLE;  // glitch, not a start bit
          else if (smp15)   state_q <= S_DATA;
        end
        S_DATA: begin
          if (smp9) data_q <= {maj, data_q[DATA_BITS-1:1]};
          if (smp15) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (smp9) begin
            par_bit_q <= maj;
            par_err_q <= (maj != par_exp);
          end
          if (smp15) state_q <= S_STOP;
        end
        S_STOP: begin
          if (smp9) begin
            if (bit_cnt_q == LAST_STOP) begin
              // The frame completes here rather than at sample 15, which
              // leaves time to resync on a slightly early next start edge.
              if (brk_now) begin
                brk_q   <= 1'b1;
                state_q <= S_BRK;
              end else begin
                state_q <= S_IDLE;
                if (!vld_q || byte_ack) begin
                  byte_q   <= data_q;
                  pe_q     <= (PARITY != 0) && par_err_q;
                  fe_out_q <= fe_now;
                  vld_q    <= 1'b1;
                end else begin
                  ovr_q <= 1'b1;
                end
              end
            end else begin
              first_stop_q <= maj;
              fe_q         <= ~maj;
            end
          end
          if (smp15) bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        S_BRK: begin
          if (rx_sync_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_data     = byte_q;
  assign byte_valid    = vld_q;
  assign parity_error  = pe_q;
  assign framing_error = fe_out_q;
  assign break_detect  = brk_q;
  assign overrun_error = ovr_q;

endmodule

// File: tb/tb_mfp_uart_receiver_cfg.sv
// Bench for mfp_uart_receiver_cfg. It drives two instances:
//   u_a : 8N1,             TICK_DIV 4 (64 clocks per bit)
//   u_b : 7 data, even, 2, TICK_DIV 5 (80 clocks per bit)
// Frames are built from whole bit periods. The expected byte and flags come
// from a frame-level model of the line format.
module tb_mfp_uart_receiver_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       rx_a = 1'b1, ack_a = 1'b0, rx_b = 1'b1, ack_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       vld_a, pe_a, fe_a, brk_a, ovr_a;
  logic       vld_b, pe_b, fe_b, brk_b, ovr_b;

  mfp_uart_receiver_cfg #(.CLOCK_FREQUENCY(7372800), .BAUD_RATE(115200)) u_a (
    .clock(clk), .reset_n(rst_n), .rx(rx_a), .byte_data(data_a),
    .byte_valid(vld_a), .byte_ack(ack_a), .parity_error(pe_a),
    .framing_error(fe_a), .break_detect(brk_a), .overrun_error(ovr_a));

  mfp_uart_receiver_cfg #(.CLOCK_FREQUENCY(9216000), .BAUD_RATE(115200),
                          .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clock(clk), .reset_n(rst_n), .rx(rx_b), .byte_data(data_b),
    .byte_valid(vld_b), .byte_ack(ack_b), .parity_error(pe_b),
    .framing_error(fe_b), .break_detect(brk_b), .overrun_error(ovr_b));

  int checks = 0, fails = 0;
  int brk_n_a = 0, ovr_n_a = 0, brk_n_b = 0, ovr_n_b = 0;
  int hi_a = 0, lo_a = 0, hi_b = 0;

  always @(negedge clk) begin
    if (brk_a) brk_n_a++;
    if (ovr_a) ovr_n_a++;
    if (brk_b) brk_n_b++;
    if (ovr_b) ovr_n_b++;
    if (vld_a) hi_a++; else lo_a++;
    if (vld_b) hi_b++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w, input logic v, input int clks);
    if (w) rx_b = v; else rx_a = v;
    repeat (clks) @(negedge clk);
  endtask

  // One frame: start, data LSB first, parity (u_b only), stops, idle gap.
  task automatic send(input bit w, input logic [8:0] d, input logic pb,
                      input logic [1:0] stp, input int gap);
    int db, bc, ns;
    db = w ? 7 : 8;
    bc = w ? 80 : 64;
    ns = w ? 2 : 1;
    drive(w, 1'b0, bc);
    for (int i = 0; i < db; i++) drive(w, d[i], bc);
    if (w) drive(w, pb, bc);
    for (int i = 0; i < ns; i++) drive(w, stp[i], bc);
    drive(w, 1'b1, gap * bc);
  endtask

  task automatic ack(input bit w);
    if (w) ack_b = 1'b1; else ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    ack_b = 1'b0;
  endtask

  // Send one frame and check it against the model. flip inverts the correct
  // parity bit. stp[i] is the value of stop bit i.
  task automatic xfer(input bit w, input logic [8:0] d, input logic flip,
                      input logic [1:0] stp, input string tag);
    logic [8:0] dm;
    logic pb, pe, fe, brk;
    int b0, o0;
    dm  = w ? {2'b0, d[6:0]} : {1'b0, d[7:0]};
    pb  = w ? ((($countones(dm) % 2) == 1) ^ flip) : 1'b0;
    pe  = w & flip;
    fe  = w ? !(stp[0] && stp[1]) : !stp[0];
    brk = (dm == 9'd0) && (!w || !pb) && !stp[0];
    b0  = w ? brk_n_b : brk_n_a;
    o0  = w ? ovr_n_b : ovr_n_a;
    send(w, dm, pb, stp, 2);
    if (brk) begin
      chk({tag, ".brk"}, (w ? brk_n_b : brk_n_a) - b0, 1);
      chk({tag, ".vld"}, w ? vld_b : vld_a, 0);
    end else begin
      chk({tag, ".vld"},  w ? vld_b : vld_a, 1);
      chk({tag, ".data"}, w ? {25'd0, data_b} : {24'd0, data_a}, {23'd0, dm});
      chk({tag, ".pe"},   w ? pe_b : pe_a, pe);
      chk({tag, ".fe"},   w ? fe_b : fe_a, fe);
      chk({tag, ".brk"},  (w ? brk_n_b : brk_n_a) - b0, 0);
      chk({tag, ".ovr"},  (w ? ovr_n_b : ovr_n_a) - o0, 0);
      repeat (8) @(negedge clk);
      chk({tag, ".hold"}, w ? vld_b : vld_a, 1);
      ack(w);
      chk({tag, ".ackclr"}, w ? vld_b : vld_a, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, o0, l0, h0;
    logic [8:0] rd;
    logic [1:0] rs;
    logic rf;

    repeat (4) @(negedge clk);
    chk("rst.vld_a", vld_a, 0);
    chk("rst.out_a", {data_a, pe_a, fe_a, brk_a, ovr_a}, 0);
    chk("rst.vld_b", vld_b, 0);
    chk("rst.out_b", {data_b, pe_b, fe_b, brk_b, ovr_b}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1
    xfer(0, 9'h0A5, 0, 2'b11, "a5");
    xfer(0, 9'h03C, 0, 2'b10, "fe3c");

    // Low for 5 ticks is shorter than half a bit, so it is not a start bit.
    b0 = brk_n_a;
    drive(0, 1'b0, 20);
    drive(0, 1'b1, 3 * 64);
    chk("glitch.vld", vld_a, 0);
    chk("glitch.brk", brk_n_a - b0, 0);
    xfer(0, 9'h03C, 0, 2'b11, "post_glitch");

    // Break: 12 bit times low
    b0 = brk_n_a;
    h0 = hi_a;
    drive(0, 1'b0, 12 * 64);
    drive(0, 1'b1, 2 * 64);
    chk("break.pulses", brk_n_a - b0, 1);
    chk("break.novld", hi_a - h0, 0);
    xfer(0, 9'h00F, 0, 2'b11, "post_break");

    // Back-to-back frames with no ack: the first byte is kept.
    o0 = ovr_n_a;
    send(0, 9'h011, 1'b0, 2'b11, 1);
    send(0, 9'h022, 1'b0, 2'b11, 2);
    chk("ovr.data", data_a, 8'h11);
    chk("ovr.vld", vld_a, 1);
    chk("ovr.pulses", ovr_n_a - o0, 1);
    ack(0);
    chk("ovr.ackclr", vld_a, 0);

    // Ack in the completion cycle of the second frame. Completion is the
    // sample-9 tick of stop bit 9: 9*64 + 10*4 clocks after the start edge
    // is seen, plus the synchroniser delay.
    send(0, 9'h011, 1'b0, 2'b11, 1);
    o0 = ovr_n_a;
    l0 = lo_a;
    fork
      send(0, 9'h022, 1'b0, 2'b11, 2);
      begin
        repeat (618) @(negedge clk);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
      end
    join
    chk("ackload.data", data_a, 8'h22);
    chk("ackload.vld", vld_a, 1);
    chk("ackload.stayhi", lo_a - l0, 0);
    chk("ackload.ovr", ovr_n_a - o0, 0);
    ack(0);

    for (int i = 0; i < 10; i++) begin
      rd = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom);
      rs = {1'b1, 1'($urandom_range(0, 4) != 0)};
      xfer(0, rd, 1'b0, rs, "rnd_a");
    end

    // A reset in the middle of a frame drops the held byte and the frame.
    send(0, 9'h05A, 1'b0, 2'b11, 1);
    chk("midrst.pre", vld_a, 1);
    drive(0, 1'b0, 64);
    drive(0, 1'b1, 3 * 64);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.vld", vld_a, 0);
    chk("midrst.data", data_a, 0);
    rst_n = 1'b1;
    drive(0, 1'b1, 2 * 64);
    xfer(0, 9'h0C3, 0, 2'b11, "post_rst");

    // 7 data bits, even parity, 2 stop bits
    xfer(1, 9'h055, 1, 2'b11, "b55_bad");
    xfer(1, 9'h055, 0, 2'b11, "b55_ok");
    xfer(1, 9'h02A, 0, 2'b01, "b_fe2");
    b0 = brk_n_b;
    h0 = hi_b;
    drive(1, 1'b0, 12 * 80);
    drive(1, 1'b1, 2 * 80);
    chk("b_break.pulses", brk_n_b - b0, 1);
    chk("b_break.novld", hi_b - h0, 0);
    xfer(1, 9'h00F, 0, 2'b11, "b_post_break");

    for (int i = 0; i < 10; i++) begin
      rd = ($urandom_range(0, 4) == 0) ? 9'd0 : 9'($urandom);
      rf = ($urandom_range(0, 2) == 0);
      rs = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
      xfer(1, rd, rf, rs, "rnd_b");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
